y_sd_recoder: RTL and testbench
===============================

Y_SD_RECODER -- requirements
Module: y_sd_recoder

Parameters
REQ-001 SHALL provide NDIG, default 4, meaning the number of BCD digits in the multiplier operand; legal range 1..16.

Interface
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-004 SHALL have port y_bcd, input, 4*NDIG bits, the multiplier operand in BCD; digit k occupies bits [4k+3:4k].
REQ-005 SHALL have port in_valid, input, 1 bit, meaning the operand is offered.
REQ-006 SHALL have port in_ready, output, 1 bit, meaning the operand can be accepted.
REQ-007 SHALL have port yi, output, bits [5:1], the one-hot magnitude of the current signed digit; bit m set means magnitude m; all-zero means magnitude 0.
REQ-008 SHALL have port ysi, output, 1 bit, the sign of the current digit; 1 means negative.
REQ-009 SHALL have port dig_idx, output, 5 bits, the position of the current digit, 0 = least significant.
REQ-010 SHALL have port out_valid, output, 1 bit, meaning yi/ysi/dig_idx hold a digit.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning the downstream multiple selector accepts the digit.
REQ-012 SHALL have port out_last, output, 1 bit, marking the final digit (index NDIG).
REQ-013 SHALL have port bcd_err, output, 1 bit, flagging that the captured operand held a digit above 9.

Function
REQ-014 SHALL recode digit y_k as t_(k+1) = 1 if y_k >= 5, else 0; d_k = y_k - 10*t_(k+1) + t_k, with t_0 = 0; d_k lies in -5..+5.
REQ-015 SHALL emit NDIG+1 digits per operand: d_0..d_(NDIG-1), then d_NDIG = t_NDIG (0 or +1).
REQ-016 SHALL drive ysi = 0 whenever the magnitude is 0, so a zero digit never inverts the selected multiple.
REQ-017 SHALL treat any digit above 9 as 0 with t_(k+1) = 0, and SHALL hold bcd_err = 1 from capture until that operand's out_last digit is accepted.
REQ-018 SHALL implement the FSM states IDLE and EMIT.
REQ-019 In IDLE, the block SHALL drive in_ready = 1 and out_valid = 0; in_valid high SHALL capture y_bcd, clear the transfer and index, and move to EMIT.
REQ-020 In EMIT, the block SHALL drive in_ready = 0 and out_valid = 1, and SHALL present digit dig_idx.
REQ-021 Each cycle in EMIT with out_ready = 1 SHALL advance to the next digit; accepting the digit with out_last = 1 SHALL return the block to IDLE.
REQ-022 SHALL present digit 0 with out_valid high in the cycle after the accept edge (latency 1).
REQ-023 SHALL sustain one digit per cycle while out_ready stays high.
REQ-024 SHALL hold the next operand off for exactly one IDLE cycle between transactions.
REQ-025 While out_valid = 1 and out_ready = 0, yi, ysi, dig_idx, out_last and bcd_err SHALL hold stable.
REQ-026 SHALL register all outputs except in_ready, which is decoded from state.
REQ-027 SHALL ignore in_valid in EMIT; y_bcd changes during EMIT SHALL NOT affect emitted digits.
REQ-028 With NDIG = 1, the block SHALL emit exactly two digits.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, yi = 0, ysi = 0, dig_idx = 0, out_valid = 0, out_last = 0 and bcd_err = 0, regardless of clk, including mid-transaction.
REQ-030 After rst_n deasserts, in_ready SHALL be 1 and no partial digit stream SHALL resume.

Verification
REQ-031 Operand y_bcd=0x1234 with out_ready held 1 -> yi/ysi over five consecutive cycles SHALL be 01000/0, 00100/0, 00010/0, 00001/0, 00000/0, with out_last on the fifth.
REQ-032 Operand y_bcd=0x9999 -> yi/ysi SHALL be 00001/1, 00000/0, 00000/0, 00000/0, 00001/0.
REQ-033 Operand y_bcd=0x5555 -> yi/ysi SHALL be 10000/1, 01000/1, 01000/1, 01000/1, 00001/0.
REQ-034 Operand y_bcd=0x4950 with out_ready low for 3 cycles at digit 1 -> digit 1 SHALL hold yi=10000 ysi=1 throughout the stall; remaining digits 00000/0, 10000/0, 00000/0.
REQ-035 Operand y_bcd=0x12A4 -> bcd_err SHALL be 1 on all five digits, and digit 1 SHALL be emitted as 00000/0.
REQ-036 rst_n pulsed low while dig_idx=2 -> out_valid SHALL go to 0 asynchronously, and a subsequent operand y_bcd=0x0000 SHALL emit five zero digits starting at dig_idx 0.

Source files
------------

// File: rtl/y_sd_recoder.sv
// Recodes a BCD multiplier operand into signed digits -5..+5 (one-hot magnitude plus sign),
// emitting NDIG+1 digits least-significant first under valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// EMIT  | presenting digit dig_idx, advancing on out_ready
module y_sd_recoder #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] y_bcd,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [5:1]        yi,
  output logic              ysi,
  output logic [4:0]        dig_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              bcd_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [4:0] LAST_IDX = 5'(NDIG);

  state_t            state, state_nxt;
  logic [4*NDIG-1:0] y_sh;
  logic              carry;
  logic [4:0]        idx_nxt;
  logic [6:0]        rec;
  logic              any_bad;
  logic              capture, advance, done;

  // Returns {t_out, negative, one-hot magnitude[5:1]}; non-BCD digits act as 0 with no transfer.
  function automatic logic [6:0] recode(input logic [3:0] y, input logic tin);
    logic [3:0] ye;
    logic [3:0] mag;
    logic       tout;
    logic       neg;
    logic [4:0] oh;
    ye   = (y > 4'd9) ? 4'd0 : y;
    tout = (ye >= 4'd5);
    if (tout) mag = 4'd10 - ye - {3'b000, tin};
    else      mag = ye + {3'b000, tin};
    neg = tout && (mag != 4'd0);
    for (int m = 1; m <= 5; m++) oh[m-1] = (mag == 4'(m));
    return {tout, neg, oh};
  endfunction

  always_comb begin
    capture = (state == IDLE) && in_valid;
    advance = (state == EMIT) && out_ready && !out_last;
    done    = (state == EMIT) && out_ready && out_last;
    idx_nxt = dig_idx + 5'd1;
    any_bad = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (y_bcd[4*k +: 4] > 4'd9) any_bad = 1'b1;
    end
    if (state == IDLE)            rec = recode(y_bcd[3:0], 1'b0);
    else if (idx_nxt == LAST_IDX) rec = recode(4'd0, carry);
    else                          rec = recode(y_sh[3:0], carry);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = EMIT;
      EMIT: if (done)     state_nxt = IDLE;
      default:            state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The operand is shifted down so the next digit to recode always sits in the low nibble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_sh      <= '0;
      carry     <= 1'b0;
      yi        <= '0;
      ysi       <= 1'b0;
      dig_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      bcd_err   <= 1'b0;
    end else if (capture) begin
      y_sh      <= y_bcd >> 4;
      carry     <= rec[6];
      yi        <= rec[4:0];
      ysi       <= rec[5];
      dig_idx   <= '0;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      bcd_err   <= any_bad;
    end else if (advance) begin
      y_sh      <= y_sh >> 4;
      carry     <= rec[6];
      yi        <= rec[4:0];
      ysi       <= rec[5];
      dig_idx   <= idx_nxt;
      out_last  <= (idx_nxt == LAST_IDX);
    end else if (done) begin
      carry     <= 1'b0;
      yi        <= '0;
      ysi       <= 1'b0;
      dig_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      bcd_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_y_sd_recoder.sv
// Bench for y_sd_recoder: directed vector table, stall/reset sequences, and randomized
// operands checked against an arithmetic signed-digit model. Also covers NDIG=1.
module tb_y_sd_recoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] y_bcd = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:1]  yi;
  logic        ysi;
  logic [4:0]  dig_idx;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        bcd_err;

  logic [3:0]  y1 = '0;
  logic        iv1 = 1'b0;
  logic        ir1;
  logic [5:1]  yi1;
  logic        ysi1;
  logic [4:0]  di1;
  logic        ov1;
  logic        or1 = 1'b0;
  logic        ol1;
  logic        be1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  y_sd_recoder #(.NDIG(4)) dut (
    .clk(clk), .rst_n(rst_n), .y_bcd(y_bcd), .in_valid(in_valid), .in_ready(in_ready),
    .yi(yi), .ysi(ysi), .dig_idx(dig_idx), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .bcd_err(bcd_err)
  );

  y_sd_recoder #(.NDIG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .y_bcd(y1), .in_valid(iv1), .in_ready(ir1),
    .yi(yi1), .ysi(ysi1), .dig_idx(di1), .out_valid(ov1), .out_ready(or1),
    .out_last(ol1), .bcd_err(be1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] pk(input logic [4:0] d0, input logic [4:0] d1,
                                     input logic [4:0] d2, input logic [4:0] d3,
                                     input logic [4:0] d4);
    return {d4, d3, d2, d1, d0};
  endfunction

  // Arithmetic reference: d_k = y_k - 10*t_(k+1) + t_k, final digit is the outgoing transfer.
  task automatic model(input logic [15:0] y, output logic [24:0] eyi,
                       output logic [4:0] eysi, output logic err);
    int t, v, d, tn, mag;
    t = 0; err = 1'b0; eyi = '0; eysi = '0;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        v = int'((y >> (4 * k)) & 16'hF);
        if (v > 9) begin v = 0; err = 1'b1; end
        tn = (v >= 5) ? 1 : 0;
        d  = v - 10 * tn + t;
        t  = tn;
      end else begin
        d = t;
      end
      mag = (d < 0) ? -d : d;
      eysi[k] = (d < 0);
      eyi[5*k +: 5] = (mag == 0) ? 5'd0 : 5'(1 << (mag - 1));
    end
  endtask

  task automatic send(input logic [15:0] y, input logic [24:0] eyi, input logic [4:0] eysi,
                      input logic eerr, input int stall_pct, input int stall_at,
                      input int stall_len);
    int k, guard, held;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    chk("in_ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1; y_bcd = y; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0; held = 0; guard = 0;
    while (k <= 4 && guard < 400) begin
      y_bcd = 16'($urandom);
      chk("out_valid", 32'(out_valid), 32'd1);
      chk("dig_idx", 32'(dig_idx), 32'(k));
      chk("yi", 32'(yi), 32'(eyi[5*k +: 5]));
      chk("ysi", 32'(ysi), 32'(eysi[k]));
      chk("out_last", 32'(out_last), 32'(k == 4));
      chk("bcd_err", 32'(bcd_err), 32'(eerr));
      if (k == stall_at && held < stall_len) begin
        out_ready = 1'b0; held++;
      end else begin
        out_ready = ($urandom_range(99) >= 32'(stall_pct));
      end
      in_valid = (k == 4 && out_ready) ? 1'b0 : 1'($urandom % 2);
      @(posedge clk); #1; guard++;
      if (out_ready) k++;
    end
    if (guard >= 400) chk("digit_timeout", 32'(guard), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("out_valid_after", 32'(out_valid), 32'd0);
    chk("in_ready_after", 32'(in_ready), 32'd1);
  endtask

  typedef struct {
    logic [15:0] y;
    logic [24:0] eyi;
    logic [4:0]  eysi;
    logic        err;
    int          stall_at;
    int          stall_len;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [24:0] m_yi;
    logic [4:0]  m_ysi;
    logic        m_err;
    logic [15:0] ry;

    tbl[0] = '{16'h1234, pk(5'b01000, 5'b00100, 5'b00010, 5'b00001, 5'b00000), 5'b00000, 1'b0, -1, 0};
    tbl[1] = '{16'h9999, pk(5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00001), 5'b00001, 1'b0, -1, 0};
    tbl[2] = '{16'h5555, pk(5'b10000, 5'b01000, 5'b01000, 5'b01000, 5'b00001), 5'b01111, 1'b0, -1, 0};
    tbl[3] = '{16'h4950, pk(5'b00000, 5'b10000, 5'b00000, 5'b10000, 5'b00000), 5'b00010, 1'b0, 1, 3};
    tbl[4] = '{16'h12A4, pk(5'b01000, 5'b00000, 5'b00010, 5'b00001, 5'b00000), 5'b00000, 1'b1, -1, 0};
    tbl[5] = '{16'h0000, pk(5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000), 5'b00000, 1'b0, -1, 0};

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_yi", 32'(yi), 32'd0);
    chk("rst_dig_idx", 32'(dig_idx), 32'd0);
    chk("rst_bcd_err", 32'(bcd_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++)
      send(tbl[i].y, tbl[i].eyi, tbl[i].eysi, tbl[i].err, 0, tbl[i].stall_at, tbl[i].stall_len);

    // Reset in the middle of a stream, with no clock edge in between.
    in_valid = 1'b1; y_bcd = 16'h5555;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_dig_idx", 32'(dig_idx), 32'd2);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_idx", 32'(dig_idx), 32'd0);
    chk("async_rst_yi", 32'(yi), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    send(tbl[5].y, tbl[5].eyi, tbl[5].eysi, tbl[5].err, 0, -1, 0);

    // Single-digit operand: 7 -> -3 then +1.
    y1 = 4'd7; iv1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0; or1 = 1'b1;
    chk("n1_d0_valid", 32'(ov1), 32'd1);
    chk("n1_d0_yi", 32'(yi1), 32'b00100);
    chk("n1_d0_ysi", 32'(ysi1), 32'd1);
    chk("n1_d0_last", 32'(ol1), 32'd0);
    @(posedge clk); #1;
    chk("n1_d1_yi", 32'(yi1), 32'b00001);
    chk("n1_d1_ysi", 32'(ysi1), 32'd0);
    chk("n1_d1_idx", 32'(di1), 32'd1);
    chk("n1_d1_last", 32'(ol1), 32'd1);
    @(posedge clk); #1;
    or1 = 1'b0;
    chk("n1_done_valid", 32'(ov1), 32'd0);
    chk("n1_ready", 32'(ir1), 32'd1);
    chk("n1_err", 32'(be1), 32'd0);

    for (int i = 0; i < 40; i++) begin
      ry = 16'($urandom);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(9) != 0 && ry[4*k +: 4] > 4'd9) ry[4*k +: 4] = 4'($urandom_range(9));
      model(ry, m_yi, m_ysi, m_err);
      send(ry, m_yi, m_ysi, m_err, 30, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
